// File: rtl/sle_bank_ctrl_pkg.sv
// Opcodes and FSM state encodings for the SLE bank command sequencer.
package sle_ctrl_pkg;

    typedef logic [2:0] op_t;
    typedef logic [2:0] state_t;

    localparam op_t OP_NOP    = 3'd0;
    localparam op_t OP_LOAD   = 3'd1;
    localparam op_t OP_CLEAR  = 3'd2;
    localparam op_t OP_PRESET = 3'd3;
    localparam op_t OP_SHIFT  = 3'd4;
    localparam op_t OP_READ   = 3'd5;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_DRIVE = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/sle_bank_ctrl_if.sv
// Command/response channel between a CSR-side master and the bank sequencer.
interface sle_bank_ctrl_if
    import sle_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             sin;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data, sin,
        input  cmd_ready, done, err, rdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, sin,
        output cmd_ready, done, err, rdata
    );
endinterface

// File: rtl/sle_bank_ctrl.sv
// Sequences load/clear/preset/shift/read commands onto a bank of SLE flip-flops
// and verifies the bank Q against an internal mirror of the expected contents.
module sle_bank_ctrl
    import sle_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    sle_bank_ctrl_if.slave   cmd,
    output logic             bank_en,
    output logic             bank_sln,
    output logic             bank_sd,
    output logic [WIDTH-1:0] bank_d,
    output logic             bank_aln,
    output logic             bank_adn,
    input  logic [WIDTH-1:0] bank_q
);

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] rdata_r;
    logic             mismatch;
    logic             bad;
    logic             aln_r;
    logic [CNTW-1:0]  req_cnt;
    logic             accept;

    assign req_cnt = CNTW'(cmd.cmd_data);

    // Ready is held off for the cycle after reset while ALn is still clearing the bank.
    assign cmd.cmd_ready = (state == ST_IDLE) && aln_r && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.done      = (state == ST_RESP);
    assign cmd.err       = (state == ST_RESP) && (mismatch || bad);
    assign cmd.rdata     = rdata_r;

    assign bank_aln = aln_r;
    assign bank_adn = 1'b1;
    assign bank_en  = (state == ST_DRIVE) || (state == ST_SHIFT);
    assign bank_sln = !((state == ST_DRIVE) && ((op_r == OP_CLEAR) || (op_r == OP_PRESET)));
    assign bank_sd  = (state == ST_DRIVE) && (op_r == OP_PRESET);

    always_comb begin
        bank_d = '0;
        if (state == ST_SHIFT)
            bank_d = {bank_q[WIDTH-2:0], cmd.sin};
        else if ((state == ST_DRIVE) && (op_r == OP_LOAD))
            bank_d = data_r;
    end

    always_ff @(posedge clk) begin
        aln_r <= !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_r     <= OP_NOP;
            data_r   <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            rdata_r  <= '0;
            mismatch <= 1'b0;
            bad      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r     <= cmd.cmd_op;
                        data_r   <= cmd.cmd_data;
                        mismatch <= 1'b0;
                        bad      <= 1'b0;
                        case (cmd.cmd_op)
                            OP_LOAD, OP_CLEAR, OP_PRESET: state <= ST_DRIVE;
                            OP_NOP, OP_READ:              state <= ST_CHECK;
                            OP_SHIFT: begin
                                if (req_cnt == '0) begin
                                    state <= ST_CHECK;
                                end else if (req_cnt > CNTW'(WIDTH)) begin
                                    bad   <= 1'b1;
                                    state <= ST_RESP;
                                end else begin
                                    cnt   <= req_cnt;
                                    state <= ST_SHIFT;
                                end
                            end
                            default: begin
                                bad   <= 1'b1;
                                state <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    case (op_r)
                        OP_LOAD:   exp_q <= data_r;
                        OP_CLEAR:  exp_q <= '0;
                        OP_PRESET: exp_q <= '1;
                        default:   exp_q <= exp_q;
                    endcase
                    state <= ST_CHECK;
                end
                ST_SHIFT: begin
                    exp_q <= {exp_q[WIDTH-2:0], cmd.sin};
                    cnt   <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1))
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    rdata_r  <= bank_q;
                    mismatch <= (bank_q != exp_q);
                    state    <= ST_RESP;
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sle_bank_ctrl.sv
// Directed bench for sle_bank_ctrl driving a behavioural bank of SLE flip-flops.
module tb_sle_bank_ctrl;
    import sle_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNTW  = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             bank_en, bank_sln, bank_sd, bank_aln, bank_adn;
    logic [WIDTH-1:0] bank_d, bank_q, disturb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sle_bank_ctrl_if #(.WIDTH(WIDTH)) cif ();

    sle_bank_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cif.slave),
        .bank_en  (bank_en),
        .bank_sln (bank_sln),
        .bank_sd  (bank_sd),
        .bank_d   (bank_d),
        .bank_aln (bank_aln),
        .bank_adn (bank_adn),
        .bank_q   (bank_q)
    );

    // WIDTH SLE cells, LAT=0: async load to ~ADn on ALn low, sync SD when SLn low.
    always @(posedge clk or negedge bank_aln) begin
        if (!bank_aln) begin
            bank_q <= {WIDTH{~bank_adn}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bank_en)         bank_q[i] <= bank_sln ? bank_d[i] : bank_sd;
                else if (disturb[i]) bank_q[i] <= ~bank_q[i];
            end
        end
    end

    typedef struct {
        string            name;
        op_t              op;
        logic [WIDTH-1:0] data;
        logic [31:0]      seq;
        int               lat;
        int               en;
        logic             err;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic run_cmd(input op_t op, input logic [WIDTH-1:0] data, input logic [31:0] seq,
                           output int lat, output int en_cyc, output logic err,
                           output logic [WIDTH-1:0] rd, output logic busy_ok, output logic ready_after);
        int w;
        w = 0;
        @(negedge clk);
        while (!cif.cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        lat = 1; en_cyc = 0; busy_ok = 1'b1;
        while (!cif.done && lat < 40) begin
            if (cif.cmd_ready) busy_ok = 1'b0;
            if (bank_en) begin
                cif.sin = seq[en_cyc % 32];
                en_cyc++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cif.done) lat = 99;
        if (bank_en) en_cyc++;
        if (cif.cmd_ready) busy_ok = 1'b0;
        err = cif.err;
        rd  = cif.rdata;
        @(posedge clk);
        #1;
        ready_after = cif.cmd_ready;
    endtask

    task automatic run_and_check(input string name, input op_t op, input logic [WIDTH-1:0] data,
                                 input logic [31:0] seq, input int lat_w, input int en_w,
                                 input logic err_w, input logic [WIDTH-1:0] rd_w);
        int lat, en_cyc;
        logic err, busy_ok, ready_after;
        logic [WIDTH-1:0] rd;
        run_cmd(op, data, seq, lat, en_cyc, err, rd, busy_ok, ready_after);
        check({name, "_lat"},   64'(lat),         64'(lat_w));
        check({name, "_en"},    64'(en_cyc),      64'(en_w));
        check({name, "_err"},   64'(err),         64'(err_w));
        check({name, "_rdata"}, 64'(rd),          64'(rd_w));
        check({name, "_busy"},  64'(busy_ok),     64'(1));
        check({name, "_ready"}, 64'(ready_after), 64'(1));
    endtask

    initial begin
        logic [23:0] rst_vec;
        logic [23:0] rst_exp;

        vt[0]  = '{"load_a5",   OP_LOAD,   8'hA5, 32'h0,  3,  1, 1'b0, 8'hA5};
        vt[1]  = '{"preset",    OP_PRESET, 8'h00, 32'h0,  3,  1, 1'b0, 8'hFF};
        vt[2]  = '{"clear",     OP_CLEAR,  8'h00, 32'h0,  3,  1, 1'b0, 8'h00};
        vt[3]  = '{"load_01",   OP_LOAD,   8'h01, 32'h0,  3,  1, 1'b0, 8'h01};
        vt[4]  = '{"shift3",    OP_SHIFT,  8'd3,  32'h5,  5,  3, 1'b0, 8'h0D};
        vt[5]  = '{"shift9",    OP_SHIFT,  8'd9,  32'h0,  1,  0, 1'b1, 8'h0D};
        vt[6]  = '{"op7",       3'd7,      8'h00, 32'h0,  1,  0, 1'b1, 8'h0D};
        vt[7]  = '{"read",      OP_READ,   8'h00, 32'h0,  2,  0, 1'b0, 8'h0D};
        vt[8]  = '{"nop",       OP_NOP,    8'h00, 32'h0,  2,  0, 1'b0, 8'h0D};
        vt[9]  = '{"shift0",    OP_SHIFT,  8'd0,  32'h0,  2,  0, 1'b0, 8'h0D};
        vt[10] = '{"shift8",    OP_SHIFT,  8'd8,  32'h35, 10, 8, 1'b0, 8'hAC};
        vt[11] = '{"op6",       3'd6,      8'h00, 32'h0,  1,  0, 1'b1, 8'hAC};

        rst = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_NOP;
        cif.cmd_data  = '0;
        cif.sin       = 1'b0;
        disturb       = '0;

        // Reset outputs: {ready,done,err,rdata,en,sln,sd,d,aln,adn}
        rst_exp = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_vec = {cif.cmd_ready, cif.done, cif.err, cif.rdata, bank_en, bank_sln, bank_sd, bank_d, bank_aln, bank_adn};
        check("reset_outputs", 64'(rst_vec), 64'(rst_exp));
        check("reset_bank_q", 64'(bank_q), 64'(0));
        rst = 1'b0;
        rst_vec = {cif.cmd_ready, cif.done, cif.err, cif.rdata, bank_en, bank_sln, bank_sd, bank_d, bank_aln, bank_adn};
        check("reset_cycle_after", 64'(rst_vec), 64'(rst_exp));
        @(posedge clk); #1;
        check("post_reset_aln", 64'(bank_aln), 64'(1));
        check("post_reset_ready", 64'(cif.cmd_ready), 64'(1));

        for (int i = 0; i < 12; i++)
            run_and_check(vt[i].name, vt[i].op, vt[i].data, vt[i].seq, vt[i].lat, vt[i].en, vt[i].err, vt[i].rd);

        // External bit flip is caught at the next CHECK and persists until reloaded.
        run_and_check("load_3c", OP_LOAD, 8'h3C, 32'h0, 3, 1, 1'b0, 8'h3C);
        @(negedge clk);
        disturb = 8'h04;
        @(posedge clk); #1;
        disturb = '0;
        run_and_check("read_flip",  OP_READ, 8'h00, 32'h0, 2, 0, 1'b1, 8'h38);
        run_and_check("read_flip2", OP_READ, 8'h00, 32'h0, 2, 0, 1'b1, 8'h38);
        run_and_check("reload_3c",  OP_LOAD, 8'h3C, 32'h0, 3, 1, 1'b0, 8'h3C);

        // Reset in the middle of a SHIFT aborts without DONE and clears the bank.
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_SHIFT;
        cif.cmd_data  = 8'd5;
        cif.sin       = 1'b1;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("midshift_en", 64'(bank_en), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midshift_done", 64'(cif.done), 64'(0));
        check("midshift_aln", 64'(bank_aln), 64'(0));
        check("midshift_q", 64'(bank_q), 64'(0));
        check("midshift_en_off", 64'(bank_en), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("midshift_done2", 64'(cif.done), 64'(0));
        check("midshift_ready", 64'(cif.cmd_ready), 64'(0));
        cif.sin = 1'b0;
        run_and_check("read_after_rst", OP_READ, 8'h00, 32'h0, 2, 0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sle_bank_ctrl.md
Name: sle_bank_ctrl

Overview:
Command sequencer for a bank of WIDTH SLE flip-flops used in flip-flop mode (LAT=0). It accepts one command at a time over a valid/ready handshake and drives the bank's EN/SLn/SD/D/ALn/ADn pins for that command. It then reads back the bank Q against an internal expected-value mirror and reports DONE with an error flag. It sits between a config/CSR master and any SLE-built register that needs controlled load, clear, preset, shift or read.

Parameters:
WIDTH, 8, bank width in bits (2..32)
CNTW, 6, shift-count field width; must satisfy 2^CNTW > WIDTH

Ports:
CLK  input  1  single clock; the bank is clocked by the same CLK
RST  input  1  synchronous, active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  controller can accept a command
CMD_OP  input  3  0 NOP, 1 LOAD, 2 CLEAR, 3 PRESET, 4 SHIFT, 5 READ; 6-7 illegal
CMD_DATA  input  WIDTH  LOAD value; SHIFT count in [CNTW-1:0]
SIN  input  1  serial-in bit for SHIFT, sampled each shift cycle
DONE  output  1  one-cycle completion pulse
ERR  output  1  valid with DONE: illegal op, bad count or readback mismatch
RDATA  output  WIDTH  bank Q captured at CHECK, valid with DONE
BANK_EN  output  1  to all SLE EN pins
BANK_SLN  output  1  to all SLE SLn pins
BANK_SD  output  1  to all SLE SD pins
BANK_D  output  WIDTH  to SLE D pins, bit i to cell i
BANK_ALN  output  1  to all SLE ALn pins
BANK_ADN  output  1  to all SLE ADn pins (tied 1: async value is 0)
BANK_Q  input  WIDTH  SLE Q pins

Behaviour:
- Clock: CLK. Reset: synchronous and active-high. All state and outputs update on posedge CLK.
- Reset, while RST=1 and the cycle after:
  - state=IDLE, CMD_READY=0, DONE=0, ERR=0, RDATA=0, BANK_EN=0, BANK_SLN=1, BANK_SD=0, BANK_D=0, EXP=0.
  - BANK_ALN=0 while RST is sampled high (registered), which clears the bank asynchronously to 0.
  - BANK_ALN=1 otherwise.
- CMD_READY=1 only in IDLE. A command is accepted at an edge where CMD_VALID&&CMD_READY; CMD_OP, CMD_DATA and the count are registered at that edge.
- States: IDLE -> DRIVE -> CHECK -> RESP -> IDLE. SHIFT path: IDLE -> SHIFT(xN) -> CHECK -> RESP.
- DRIVE, exactly 1 cycle with BANK_EN=1:
  - LOAD: BANK_SLN=1, BANK_D=data, EXP<=data.
  - CLEAR: BANK_SLN=0, BANK_SD=0, EXP<=0.
  - PRESET: BANK_SLN=0, BANK_SD=1, EXP<=all ones.
- READ and NOP skip DRIVE and go IDLE->CHECK; BANK_EN stays 0.
- Illegal op goes IDLE->RESP with ERR=1; the bank is untouched.
- SHIFT with count N:
  - N=0 behaves as NOP.
  - N>WIDTH goes to RESP with ERR=1 and no drive.
  - Otherwise N cycles in SHIFT with BANK_EN=1, BANK_SLN=1, BANK_D={BANK_Q[WIDTH-2:0],SIN}, and EXP<={EXP[WIDTH-2:0],SIN}. The counter decrements each cycle; leave SHIFT when the counter reaches 1.
- CHECK, 1 cycle: RDATA<=BANK_Q; mismatch<=(BANK_Q!=EXP).
- RESP, 1 cycle: DONE=1, ERR=mismatch or illegal/bad-count flag. RDATA holds until the next DONE.
- Latency from the accept edge to the DONE-high cycle:
  - LOAD/CLEAR/PRESET: 3 cycles.
  - READ/NOP: 2 cycles.
  - SHIFT N: N+2 cycles.
  - Illegal op: 1 cycle.
- BANK_EN is never high outside DRIVE or SHIFT. BANK_SLN returns to 1 whenever BANK_EN=0.
- CMD_VALID while busy is ignored (no queueing). Back-to-back commands: the next accept is possible in the cycle after RESP.
- RST mid-operation: abort immediately, no DONE. The bank is cleared via ALn and EXP=0.
- An external bank disturbance is detected only at the next CHECK, reported as ERR with RDATA showing the actual value.

Decomposition:
- Shared package sle_ctrl_pkg holds:
  - opcode constants OP_NOP..OP_READ;
  - state encoding ST_IDLE, ST_DRIVE, ST_SHIFT, ST_CHECK, ST_RESP.
- No sub-module needed for the RTL. The bench instantiates WIDTH SLE cells (LAT=0) as the real bank.

Test Plan:
- Reset then LOAD 0xA5 -> DONE 3 cycles after accept, ERR=0, RDATA=0xA5, BANK_EN high exactly 1 cycle.
- PRESET then CLEAR back-to-back -> RDATA 0xFF then 0x00, both ERR=0; CMD_READY low while busy.
- LOAD 0x01, SHIFT count 3 with SIN=1,0,1 -> 3 EN cycles, RDATA=0x0D, DONE at accept+5.
- SHIFT count 9 (WIDTH=8) -> DONE 1 cycle after accept, ERR=1, bank unchanged. Opcode 7 behaves the same.
- LOAD 0x3C, then force a bank bit flip externally, then READ -> ERR=1 with RDATA showing the flipped value.
- RST asserted mid-SHIFT -> no DONE, BANK_ALN low, bank Q=0; a following READ returns 0x00 with ERR=0.
